add_sub_unit: RTL and testbench



---
 rtl/add_sub_pkg.sv | 17 +
 rtl/add_sub_cla.sv | 34 +++
 rtl/add_sub_unit.sv | 91 +++++++++
 tb/tb_add_sub_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the add/subtract unit.
package add_sub_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CLA_W     = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sub_cla.sv
// 4-bit carry-lookahead group: bit generate/propagate, internal carries and group carry out.
module add_sub_cla
    import add_sub_pkg::*;
(
    input  logic [CLA_W-1:0] i_a,
    input  logic [CLA_W-1:0] i_b,
    input  logic             i_c,
    output logic [CLA_W-1:0] o_sum,
    output logic             o_c
);

    logic [CLA_W-1:0] w_g;
    logic [CLA_W-1:0] w_p;
    logic [CLA_W-1:0] w_c;
    logic             w_gg;
    logic             w_gp;

    // Lookahead carries computed directly from g/p rather than rippled bit by bit.
    always_comb begin
        w_g    = i_a & i_b;
        w_p    = i_a ^ i_b;
        w_c[0] = i_c;
        w_c[1] = w_g[0] | (w_p[0] & i_c);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_c);
        w_gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        w_gp   = &w_p;
        o_c    = w_gg | (w_gp & i_c);
        o_sum  = w_p ^ w_c;
    end

endmodule

// File: rtl/add_sub_unit.sv
// WIDTH-bit adder/subtractor with carry/borrow, zero and signed-overflow flags.
// Combinational by default; define ADD_SUB_OUT_REG_EN to register all outputs (1-cycle latency).
module add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int unsigned NUM_GROUPS = WIDTH / CLA_W;

    mode_e            w_mode;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [NUM_GROUPS:0] w_carry;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_zero;
    logic             w_ovf;

    // Subtract is a + ~b + 1: invert B and feed the mode bit in as carry-in.
    always_comb begin
        w_mode     = mode_e'(cin_i);
        w_sub      = (w_mode == MODE_SUB);
        w_b_eff    = b_i ^ {WIDTH{w_sub}};
        w_carry[0] = w_sub;
    end

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
        add_sub_cla u_cla (
            .i_a   (a_i[gi*CLA_W +: CLA_W]),
            .i_b   (w_b_eff[gi*CLA_W +: CLA_W]),
            .i_c   (w_carry[gi]),
            .o_sum (w_result[gi*CLA_W +: CLA_W]),
            .o_c   (w_carry[gi+1])
        );
    end

    // Flags; the subtract-mode carry is inverted so cout reads as a borrow.
    always_comb begin
        w_cout = w_carry[NUM_GROUPS] ^ w_sub;
        w_zero = ~|w_result;
        w_ovf  = ovf_f(a_i[WIDTH-1], w_b_eff[WIDTH-1], w_result[WIDTH-1]);
    end

`ifdef ADD_SUB_OUT_REG_EN
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;

    // Output register stage; reset clears every output, zero flag included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_cout   <= w_cout;
            r_zero   <= w_zero;
            r_ovf    <= w_ovf;
        end
    end

    assign result_o = r_result;
    assign cout_o   = r_cout;
    assign zero_o   = r_zero;
    assign ovf_o    = r_ovf;
`else
    // Clock and reset are kept on the port list so both builds share one interface.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk_i ^ rst_ni;

    assign result_o = w_result;
    assign cout_o   = w_cout;
    assign zero_o   = w_zero;
    assign ovf_o    = w_ovf;
`endif

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit (WIDTH = 32), default or ADD_SUB_OUT_REG_EN build.
module tb_add_sub_unit;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cin_i;
    logic [31:0] result_o;
    logic        cout_o;
    logic        zero_o;
    logic        ovf_o;

    int n_pass;
    int n_total;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    add_sub_unit #(
        .WIDTH (32)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .a_i      (a_i),
        .b_i      (b_i),
        .cin_i    (cin_i),
        .result_o (result_o),
        .cout_o   (cout_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: plain unsigned/signed arithmetic on wide integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [32:0] full;
        longint      sa;
        longint      sb;
        longint      s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b};
            e.r  = full[31:0];
            e.c  = full[32];
            s    = sa + sb;
        end else begin
            e.r = a - b;
            e.c = (a < b);
            s   = sa - sb;
        end
        e.z = (e.r == 32'h0);
        e.v = (s > SMAX) || (s < SMIN);
        return e;
    endfunction

    // Apply one vector and wait until the outputs should reflect it.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
`ifdef ADD_SUB_OUT_REG_EN
        @(negedge clk_i);
        a_i   = a;
        b_i   = b;
        cin_i = c;
        @(posedge clk_i);
        #1;
`else
        a_i   = a;
        b_i   = b;
        cin_i = c;
        #10;
`endif
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        a_i    = 32'h1;
        b_i    = 32'h1;
        cin_i  = 1'b0;
        #2;
`ifdef ADD_SUB_OUT_REG_EN
        n_total++;
        if ({result_o, cout_o, zero_o, ovf_o} !== 35'h0)
            $display("FAIL reset_outputs: got %h expected 0", {result_o, cout_o, zero_o, ovf_o});
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        n_total++;
        if (result_o !== 32'h2)
            $display("FAIL first_load: got %h expected 00000002", result_o);
        else n_pass++;
`else
        // Reset has no effect on the combinational build.
        #8;
        n_total++;
        if (result_o !== 32'h2)
            $display("FAIL reset_ignored: got %h expected 00000002", result_o);
        else n_pass++;
        rst_ni = 1'b1;
`endif
    endtask

    task automatic test_directed;
        logic [31:0] ta [7] = '{32'h1, 32'h3039, 32'hFFFFFFFF, 32'hA,
                                32'h2F145, 32'h1, 32'h7FFFFFFF};
        logic [31:0] tb [7] = '{32'h1, 32'h1A85, 32'h1, 32'h9,
                                32'hF1206, 32'h1, 32'h1};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] er [7] = '{32'h2, 32'h4ABE, 32'h0, 32'h1,
                                32'hFFF3DF3F, 32'h0, 32'h80000000};
        logic        ec [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ez [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        ev [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(ta[i], tb[i], tc[i]);
            n_total++;
            if (result_o !== er[i])
                $display("FAIL directed%0d result: got %h expected %h", i, result_o, er[i]);
            else n_pass++;
            n_total++;
            if (cout_o !== ec[i])
                $display("FAIL directed%0d cout: got %b expected %b", i, cout_o, ec[i]);
            else n_pass++;
            n_total++;
            if (zero_o !== ez[i])
                $display("FAIL directed%0d zero: got %b expected %b", i, zero_o, ez[i]);
            else n_pass++;
            n_total++;
            if (ovf_o !== ev[i])
                $display("FAIL directed%0d ovf: got %b expected %b", i, ovf_o, ev[i]);
            else n_pass++;
        end
    endtask

    // Operands biased towards sign/carry boundaries, otherwise uniform.
    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                                     32'hFFFFFFFF, 32'h80000001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random;
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        for (int i = 0; i < 300; i++) begin
            a = pick_operand();
            b = (i % 10 == 0) ? a : pick_operand();
            c = 1'($urandom_range(0, 1));
            e = model(a, b, c);
            drive(a, b, c);
            n_total++;
            if ({result_o, cout_o, zero_o, ovf_o} !== {e.r, e.c, e.z, e.v})
                $display("FAIL random a=%h b=%h cin=%b: got r=%h c=%b z=%b v=%b expected r=%h c=%b z=%b v=%b",
                         a, b, c, result_o, cout_o, zero_o, ovf_o, e.r, e.c, e.z, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_mode_toggle;
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            for (int m = 0; m < 2; m++) begin
                e = model(a, b, 1'(m));
                drive(a, b, 1'(m));
                n_total++;
                if ({result_o, cout_o, zero_o, ovf_o} !== {e.r, e.c, e.z, e.v})
                    $display("FAIL toggle a=%h b=%h cin=%0d: got r=%h c=%b z=%b v=%b expected r=%h c=%b z=%b v=%b",
                             a, b, m, result_o, cout_o, zero_o, ovf_o, e.r, e.c, e.z, e.v);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(32'hFFFFFFFF, 32'h1, 1'b0);
`ifdef ADD_SUB_OUT_REG_EN
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({result_o, cout_o, zero_o, ovf_o} !== 35'h0)
            $display("FAIL reset_mid: got %h expected 0", {result_o, cout_o, zero_o, ovf_o});
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(32'h7FFFFFFF, 32'h1, 1'b0);
        n_total++;
        if ({result_o, ovf_o} !== {32'h80000000, 1'b1})
            $display("FAIL reset_recover: got %h/%b expected 80000000/1", result_o, ovf_o);
        else n_pass++;
`else
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({result_o, cout_o, zero_o} !== {32'h0, 1'b1, 1'b1})
            $display("FAIL reset_mid_comb: got %h/%b/%b expected 00000000/1/1",
                     result_o, cout_o, zero_o);
        else n_pass++;
        rst_ni = 1'b1;
`endif
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_ni  = 1'b1;
        a_i     = '0;
        b_i     = '0;
        cin_i   = 1'b0;
        #2;
        test_reset();
        test_directed();
        test_random();
        test_mode_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
